deallocate: RTL and testbench

DEALLOCATE -- requirements
Module: deallocate

---
 rtl/deallocate.sv | 151 +++++++++++++++
 tb/tb_deallocate.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deallocate.sv
// Repacks variable-width MSB-aligned input chunks (0..38 bits) into 32-bit output words,
// framed by packet start/end with first/last qualifiers and protocol-violation flagging.
module deallocate (
    input  logic        clk,
    input  logic        rst,
    input  logic        sop_in,
    input  logic        new_word_a,
    input  logic        first_word_a,
    input  logic        last_word_a,
    input  logic [37:0] word_a,
    input  logic [5:0]  num_values_a,
    output logic        ready_a,
    output logic [31:0] word_r,
    output logic        new_word_r,
    output logic        first_word_r,
    output logic        last_word_r,
    output logic        packet_in_progress,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e      state_q, state_d;
    logic [69:0] bits_q, bits_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        first_out_q, first_out_d;
    logic        first_in_q, first_in_d;
    logic [31:0] word_d;
    logic        new_d, first_d, last_d, pip_d, err_d;

    logic [5:0]  n_sat;
    logic [37:0] chunk;
    logic [69:0] chunk_ext;
    logic        accept, emit_full, flush_tail;

    always_comb begin
        n_sat      = (num_values_a > 6'd38) ? 6'd38 : num_values_a;
        // Keep only the top n bits; anything below is don't-care on the input.
        chunk      = word_a & ~(38'h3F_FFFF_FFFF >> n_sat);
        chunk_ext  = {chunk, 32'd0} >> cnt_q;
        ready_a    = (state_q == StRun) && (cnt_q < 7'd32);
        accept     = new_word_a && ready_a;
        emit_full  = (state_q != StIdle) && (cnt_q >= 7'd32);
        flush_tail = (state_q == StFlush) && (cnt_q < 7'd32);
    end

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        cnt_d       = cnt_q;
        first_out_d = first_out_q;
        first_in_d  = first_in_q;
        word_d      = word_r;
        new_d       = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        pip_d       = packet_in_progress;

        unique case (state_q)
            StIdle: begin
                pip_d  = 1'b0;
                bits_d = '0;
                cnt_d  = '0;
                if (sop_in) begin
                    state_d     = StRun;
                    pip_d       = 1'b1;
                    first_out_d = 1'b1;
                    first_in_d  = 1'b1;
                    // A chunk alongside sop_in cannot be taken yet.
                    err_d       = new_word_a;
                end
            end
            StRun, StFlush: begin
                if (sop_in || (new_word_a && !ready_a)) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    bits_d = bits_q | chunk_ext;
                    cnt_d  = cnt_q + {1'b0, n_sat};
                    if (num_values_a > 6'd38) begin
                        err_d = 1'b1;
                    end
                    if (first_in_q) begin
                        first_in_d = 1'b0;
                        if (!first_word_a) begin
                            err_d = 1'b1;
                        end
                    end else if (first_word_a) begin
                        err_d = 1'b1;
                    end
                    if (last_word_a) begin
                        state_d = StFlush;
                    end
                end
                if (emit_full) begin
                    word_d      = bits_q[69:38];
                    new_d       = 1'b1;
                    first_d     = first_out_q;
                    first_out_d = 1'b0;
                    bits_d      = bits_q << 32;
                    cnt_d       = cnt_q - 7'd32;
                    if ((state_q == StFlush) && (cnt_q == 7'd32)) begin
                        last_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (flush_tail) begin
                    // Remainder is already zero-padded below the valid bits.
                    word_d      = bits_q[69:38];
                    new_d       = 1'b1;
                    first_d     = first_out_q;
                    last_d      = 1'b1;
                    first_out_d = 1'b0;
                    bits_d      = '0;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StIdle;
            bits_q             <= '0;
            cnt_q              <= '0;
            first_out_q        <= 1'b0;
            first_in_q         <= 1'b0;
            word_r             <= '0;
            new_word_r         <= 1'b0;
            first_word_r       <= 1'b0;
            last_word_r        <= 1'b0;
            packet_in_progress <= 1'b0;
            error              <= 1'b0;
        end else begin
            state_q            <= state_d;
            bits_q             <= bits_d;
            cnt_q              <= cnt_d;
            first_out_q        <= first_out_d;
            first_in_q         <= first_in_d;
            word_r             <= word_d;
            new_word_r         <= new_d;
            first_word_r       <= first_d;
            last_word_r        <= last_d;
            packet_in_progress <= pip_d;
            error              <= err_d;
        end
    end

endmodule

// File: tb/tb_deallocate.sv
// Directed bench for deallocate: reset, repacking scenarios, flush cases and protocol errors.
module tb_deallocate;

    logic        clk = 1'b0;
    logic        rst;
    logic        sop_in, new_word_a, first_word_a, last_word_a;
    logic [37:0] word_a;
    logic [5:0]  num_values_a;
    logic        ready_a;
    logic [31:0] word_r;
    logic        new_word_r, first_word_r, last_word_r, packet_in_progress, error;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    bit drv_fail = 1'b0;
    logic [33:0] words_q[$];  // {first, last, word}

    localparam logic [37:0] Ones = 38'h3F_FFFF_FFFF;

    deallocate dut (
        .clk               (clk),
        .rst               (rst),
        .sop_in            (sop_in),
        .new_word_a        (new_word_a),
        .first_word_a      (first_word_a),
        .last_word_a       (last_word_a),
        .word_a            (word_a),
        .num_values_a      (num_values_a),
        .ready_a           (ready_a),
        .word_r            (word_r),
        .new_word_r        (new_word_r),
        .first_word_r      (first_word_r),
        .last_word_r       (last_word_r),
        .packet_in_progress(packet_in_progress),
        .error             (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_word_r) words_q.push_back({first_word_r, last_word_r, word_r});
        if (error) err_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sop_in       = 1'b0;
        new_word_a   = 1'b0;
        first_word_a = 1'b0;
        last_word_a  = 1'b0;
        word_a       = '0;
        num_values_a = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        words_q.delete();
    endtask

    task automatic start_packet();
        sop_in = 1'b1;
        tick();
        sop_in = 1'b0;
    endtask

    task automatic send_chunk(input logic [37:0] w, input logic [5:0] n, input logic f,
                              input logic l);
        int waited = 0;
        while (!ready_a && waited < 40) begin
            tick();
            waited++;
        end
        if (!ready_a) begin
            drv_fail = 1'b1;
            return;
        end
        new_word_a   = 1'b1;
        word_a       = w;
        num_values_a = n;
        first_word_a = f;
        last_word_a  = l;
        tick();
        idle_inputs();
    endtask

    task automatic wait_done();
        int waited = 0;
        while (packet_in_progress && waited < 60) begin
            tick();
            waited++;
        end
        if (packet_in_progress) drv_fail = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++;
        if ({ready_a, new_word_r, first_word_r, last_word_r, packet_in_progress, error} !== 6'b0)
        begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {ready_a, new_word_r, first_word_r, last_word_r, packet_in_progress, error});
        end
        checks++;
        if (word_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_word got %h want 00000000", word_r);
        end
        do_reset();
        // Chunk in IDLE without sop_in is silently ignored.
        new_word_a   = 1'b1;
        word_a       = Ones;
        num_values_a = 6'd32;
        tick();
        idle_inputs();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore_error got %b want 0", error);
        end
        tick();
        checks++;
        if (words_q.size() !== 0 || packet_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got %0d words pip %b want 0 words pip 0",
                     words_q.size(), packet_in_progress);
        end
    endtask

    task automatic test_four_words();
        logic [31:0] vals[4] = '{32'hF00CC05A, 32'h7D000007, 32'h00000020, 32'hFE000000};
        int e0;
        do_reset();
        e0 = err_seen;
        start_packet();
        checks++;
        if (packet_in_progress !== 1'b1 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL sop_taken got pip %b ready %b want 1 1", packet_in_progress, ready_a);
        end
        for (int i = 0; i < 4; i++) send_chunk({vals[i], 6'b0}, 6'd32, i == 0, i == 3);
        wait_done();
        checks++;
        if (words_q.size() !== 4) begin
            errors++;
            $display("FAIL four_count got %0d want 4", words_q.size());
        end
        for (int i = 0; i < 4 && i < words_q.size(); i++) begin
            checks++;
            if (words_q[i] !== {i == 0, i == 3, vals[i]}) begin
                errors++;
                $display("FAIL four_word%0d got %h want %h", i, words_q[i],
                         {i == 0, i == 3, vals[i]});
            end
        end
        checks++;
        if (err_seen - e0 !== 0 || packet_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL four_clean got errs %0d pip %b want 0 0", err_seen - e0,
                     packet_in_progress);
        end
    endtask

    task automatic test_split();
        do_reset();
        start_packet();
        send_chunk(Ones, 6'd38, 1'b1, 1'b0);
        send_chunk(38'h0, 6'd26, 1'b0, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 2 || words_q[0] !== {2'b10, 32'hFFFFFFFF}
            || words_q[1] !== {2'b01, 32'hFC000000}) begin
            errors++;
            $display("FAIL split got %0d words %h %h want 2 words 2ffffffff 1fc000000",
                     words_q.size(), words_q[0], words_q[1]);
        end
    endtask

    task automatic test_single_and_zero();
        do_reset();
        start_packet();
        send_chunk(38'h2A_B000_0000, 6'd12, 1'b1, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 1 || words_q[0] !== {2'b11, 32'hAAC00000}) begin
            errors++;
            $display("FAIL single got %0d words %h want 1 word 3aac00000",
                     words_q.size(), words_q[0]);
        end
        words_q.delete();
        start_packet();
        send_chunk(Ones, 6'd0, 1'b1, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 1 || words_q[0] !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL zero_pkt got %0d words %h want 1 word 300000000",
                     words_q.size(), words_q[0]);
        end
    endtask

    task automatic test_drop();
        int e0;
        do_reset();
        e0 = err_seen;
        start_packet();
        send_chunk(Ones, 6'd38, 1'b1, 1'b0);
        checks++;
        if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready got %b want 0", ready_a);
        end
        new_word_a   = 1'b1;
        word_a       = '0;
        num_values_a = 6'd10;
        tick();
        idle_inputs();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL drop_error got %b want 1", error);
        end
        send_chunk(Ones, 6'd26, 1'b0, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 2 || words_q[0] !== {2'b10, 32'hFFFFFFFF}
            || words_q[1] !== {2'b01, 32'hFFFFFFFF} || err_seen - e0 !== 1) begin
            errors++;
            $display("FAIL drop_words got %0d words %h %h errs %0d want 2ffffffff 1ffffffff 1",
                     words_q.size(), words_q[0], words_q[1], err_seen - e0);
        end
    endtask

    task automatic test_errors();
        int e0;
        do_reset();
        e0 = err_seen;
        start_packet();
        send_chunk(Ones, 6'd45, 1'b1, 1'b0);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL sat_error got %b want 1", error);
        end
        sop_in = 1'b1;
        tick();
        sop_in = 1'b0;
        checks++;
        if (error !== 1'b1 || packet_in_progress !== 1'b1) begin
            errors++;
            $display("FAIL sop_in_run got err %b pip %b want 1 1", error, packet_in_progress);
        end
        send_chunk(38'h0, 6'd26, 1'b0, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 2 || words_q[0] !== {2'b10, 32'hFFFFFFFF}
            || words_q[1] !== {2'b01, 32'hFC000000} || err_seen - e0 !== 2) begin
            errors++;
            $display("FAIL err_words got %0d words %h %h errs %0d want 2ffffffff 1fc000000 2",
                     words_q.size(), words_q[0], words_q[1], err_seen - e0);
        end
    endtask

    task automatic test_first_flags();
        int e0;
        do_reset();
        e0 = err_seen;
        start_packet();
        send_chunk({16'hABCD, 22'h0}, 6'd16, 1'b0, 1'b0);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL missing_first got %b want 1", error);
        end
        send_chunk({16'h1234, 22'h0}, 6'd16, 1'b1, 1'b1);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL late_first got %b want 1", error);
        end
        wait_done();
        checks++;
        if (words_q.size() !== 1 || words_q[0] !== {2'b11, 32'hABCD1234} || err_seen - e0 !== 2)
        begin
            errors++;
            $display("FAIL first_flags got %0d words %h errs %0d want 3abcd1234 2",
                     words_q.size(), words_q[0], err_seen - e0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_packet();
        send_chunk(Ones, 6'd20, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready_a, new_word_r, first_word_r, last_word_r, packet_in_progress, error} !== 6'b0
            || word_r !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got flags %b word %h want 000000 00000000",
                     {ready_a, new_word_r, first_word_r, last_word_r, packet_in_progress, error},
                     word_r);
        end
        tick();
        rst = 1'b0;
        words_q.delete();
        repeat (10) tick();
        checks++;
        if (words_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet got %0d words want 0", words_q.size());
        end
        start_packet();
        checks++;
        if (packet_in_progress !== 1'b1) begin
            errors++;
            $display("FAIL sop_after_reset got %b want 1", packet_in_progress);
        end
        send_chunk(38'h0, 6'd20, 1'b1, 1'b1);
        wait_done();
        checks++;
        if (words_q.size() !== 1 || words_q[0] !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL post_reset_pkt got %0d words %h want 1 word 300000000",
                     words_q.size(), words_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_four_words();
        test_split();
        test_single_and_zero();
        test_drop();
        test_errors();
        test_first_flags();
        test_reset_mid();
        checks++;
        if (drv_fail) begin
            errors++;
            $display("FAIL handshake_timeout got timeout want none");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
